memory_arbiter: RTL and testbench
=================================

# memory_arbiter

Shares one single-port unified memory between the instruction-fetch port and the data-memory port of the 5-stage pipeline. It grants one request at a time, using fixed data-port priority with a starvation guard for fetch. It sequences a request/acknowledge transaction to the memory and returns registered read data with a one-cycle ready pulse. It also produces per-port stall signals that feed the pipeline stall logic.

## Interface
- ADDR_WIDTH, 32, address width of both ports and memory
- DATA_WIDTH, 32, data width
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (≥1)
- clk  in  1  clock, rising edge
- resetN  in  1  asynchronous, active-low reset
- ifReq  in  1  fetch read request; held with ifAddr stable until ifReady
- ifAddr  in  ADDR_WIDTH  fetch address
- ifReady  out  1  one-cycle pulse: ifData valid
- ifData  out  DATA_WIDTH  registered fetch read data
- ifStall  out  1  ifReq & ~ifReady (combinational)
- dmReq  in  1  data request; held with dmWrite/dmAddr/dmWriteData stable until dmReady
- dmWrite  in  1  1 = store, 0 = load
- dmAddr  in  ADDR_WIDTH  data address
- dmWriteData  in  DATA_WIDTH  store data
- dmReady  out  1  one-cycle pulse: transaction complete, dmReadData valid for loads
- dmReadData  out  DATA_WIDTH  registered load data
- dmStall  out  1  dmReq & ~dmReady (combinational)
- memReq  out  1  memory request, held until memAck
- memWrite  out  1  write strobe qualifying memReq
- memAddr  out  ADDR_WIDTH  memory address
- memWriteData  out  DATA_WIDTH  memory write data
- memAck  in  1  one-cycle completion; memReadData valid this cycle; never in the first memReq cycle
- memReadData  in  DATA_WIDTH  memory read data

## Operation
- States:
  - IDLE: no transaction in flight.
  - BUSY_IF: fetch transaction in flight.
  - BUSY_DM: data transaction in flight.
  - RESP: ready pulse cycle.
- IDLE, no request: stay in IDLE.
- IDLE, grant on the clock edge:
  - dmReq only → BUSY_DM.
  - ifReq only → BUSY_IF.
  - Both → BUSY_DM, unless starveCount == STARVE_LIMIT; then → BUSY_IF.
- On grant, register memReq=1, memWrite (dmWrite for data, 0 for fetch), memAddr, memWriteData (0 for fetch).
- BUSY_x: hold all mem outputs constant until memAck.
- On memAck:
  - Drop memReq and memWrite.
  - Latch memReadData into ifData (BUSY_IF) or into dmReadData (BUSY_DM loads only).
  - Store: dmReadData is unchanged.
  - → RESP.
- RESP:
  - Assert ifReady or dmReady for exactly one cycle.
  - No grant is made in this cycle, so the still-high request is not re-granted.
  - → IDLE.
- starveCount (width clog2(STARVE_LIMIT+1)), updated on each grant:
  - DM grant with ifReq=1 → +1, saturating at STARVE_LIMIT.
  - DM grant with ifReq=0 → 0.
  - IF grant → 0.
- A request dropped before its ready arrives is a protocol violation; behaviour is undefined.
- memAck outside BUSY_x is ignored.

## Timing
- Reset (asynchronous, takes effect immediately):
  - memReq, memWrite, ifReady, dmReady = 0.
  - memAddr, memWriteData, ifData, dmReadData = 0.
  - State = IDLE, starveCount = 0.
- Reset mid-transaction aborts it; memReq drops without waiting for memAck. After resetN rises, the first grant is possible on the first edge.
- Request first seen high at edge E0:
  - memReq high from E0.
  - memAck at earliest cycle E0+1.
  - Ready pulse in the cycle after memAck.
  - Minimum request-to-ready latency: 3 cycles.
- Back-to-back throughput: one transaction per (memory latency + 2) cycles. The RESP cycle is a mandatory bubble.
- Stall outputs are combinational from req and ready, with no extra register, so the pipeline freezes in the same cycle.

## Test plan
- Reset: hold resetN=0 with ifReq=1. Required: all outputs 0 and memReq=0. Release; memReq=1 with memAddr=ifAddr one edge later.
- Single fetch: ifAddr=0x40, memAck 2 cycles after memReq with memReadData=0x00500093. Required: ifReady pulses 1 cycle, the cycle after memAck, with ifData=0x00500093. ifStall=1 until that cycle.
- Store then load:
  - Store dmWrite=1, dmAddr=0x100, dmWriteData=0xDEADBEEF. Required: memWrite=1 with matching memAddr/memWriteData; dmReady pulse; dmReadData unchanged.
  - Then load 0x100 with memReadData=0xDEADBEEF. Required: dmReadData=0xDEADBEEF.
- Priority and starvation: hold ifReq and dmReq continuously, STARVE_LIMIT=4. Required: grant order DM, DM, DM, DM, IF, DM, …
- Reset mid-transaction: assert resetN=0 while in BUSY_DM before memAck. Required: memReq=0 immediately, no dmReady pulse, starveCount=0. The next request is serviced normally.
- Ack ordering: memAck held 0 for 10 cycles. Required: memReq/memAddr stable all 10 cycles. A spurious memAck in IDLE produces no ready pulse.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Bundle of the fetch, data and unified-memory handshakes around memory_arbiter.
// The slave side is the arbiter; the master side is the pipeline plus memory.
interface memory_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  ifReq;
    logic [ADDR_WIDTH-1:0] ifAddr;
    logic                  ifReady;
    logic [DATA_WIDTH-1:0] ifData;
    logic                  ifStall;

    logic                  dmReq;
    logic                  dmWrite;
    logic [ADDR_WIDTH-1:0] dmAddr;
    logic [DATA_WIDTH-1:0] dmWriteData;
    logic                  dmReady;
    logic [DATA_WIDTH-1:0] dmReadData;
    logic                  dmStall;

    logic                  memReq;
    logic                  memWrite;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memWriteData;
    logic                  memAck;
    logic [DATA_WIDTH-1:0] memReadData;

    modport slave (
        input  ifReq, ifAddr, dmReq, dmWrite, dmAddr, dmWriteData, memAck, memReadData,
        output ifReady, ifData, ifStall, dmReady, dmReadData, dmStall,
               memReq, memWrite, memAddr, memWriteData
    );

    modport master (
        output ifReq, ifAddr, dmReq, dmWrite, dmAddr, dmWriteData, memAck, memReadData,
        input  ifReady, ifData, ifStall, dmReady, dmReadData, dmStall,
               memReq, memWrite, memAddr, memWriteData
    );
endinterface

// File: rtl/memory_arbiter.sv
// Single-port memory arbiter between fetch and data ports: data has priority,
// fetch wins after STARVE_LIMIT consecutive data grants taken while it waited.
module memory_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic resetN,
    memory_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_IF = 2'd1;
    localparam logic [1:0] BUSY_DM = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    logic [1:0]            state;
    logic [CW-1:0]         starve_count;
    logic                  mem_req;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  if_ready;
    logic                  dm_ready;
    logic [DATA_WIDTH-1:0] if_data;
    logic [DATA_WIDTH-1:0] dm_rdata;

    logic starved;
    logic grant_dm;
    logic grant_if;

    assign starved  = (starve_count == LIMIT);
    assign grant_dm = bus.dmReq & ~(bus.ifReq & starved);
    assign grant_if = bus.ifReq & ~grant_dm;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            starve_count <= '0;
            mem_req      <= 1'b0;
            mem_write    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            if_ready     <= 1'b0;
            dm_ready     <= 1'b0;
            if_data      <= '0;
            dm_rdata     <= '0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state     <= BUSY_DM;
                        mem_req   <= 1'b1;
                        mem_write <= bus.dmWrite;
                        mem_addr  <= bus.dmAddr;
                        mem_wdata <= bus.dmWriteData;
                        // count only data grants that made a waiting fetch wait longer
                        if (!bus.ifReq)
                            starve_count <= '0;
                        else if (!starved)
                            starve_count <= starve_count + 1'b1;
                    end else if (grant_if) begin
                        state        <= BUSY_IF;
                        mem_req      <= 1'b1;
                        mem_write    <= 1'b0;
                        mem_addr     <= bus.ifAddr;
                        mem_wdata    <= '0;
                        starve_count <= '0;
                    end
                end
                BUSY_IF: begin
                    if (bus.memAck) begin
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        mem_write <= 1'b0;
                        if_data   <= bus.memReadData;
                        if_ready  <= 1'b1;
                    end
                end
                BUSY_DM: begin
                    if (bus.memAck) begin
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        mem_write <= 1'b0;
                        if (!mem_write)
                            dm_rdata <= bus.memReadData;
                        dm_ready  <= 1'b1;
                    end
                end
                // RESP is a bubble so a request still held high is not re-granted
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.memReq       = mem_req;
    assign bus.memWrite     = mem_write;
    assign bus.memAddr      = mem_addr;
    assign bus.memWriteData = mem_wdata;
    assign bus.ifReady      = if_ready;
    assign bus.ifData       = if_data;
    assign bus.dmReady      = dm_ready;
    assign bus.dmReadData   = dm_rdata;
    assign bus.ifStall      = bus.ifReq & ~if_ready;
    assign bus.dmStall      = bus.dmReq & ~dm_ready;
endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: memory responder, rule-level monitor model,
// directed vector table, starvation/reset sequences and randomized contention.
module tb_memory_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic resetN;
    int   checks = 0;
    int   errors = 0;

    memory_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    memory_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .resetN(resetN), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // memory seen by the DUT, and the model's own view of memory contents
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
    endfunction
    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : (a ^ 32'h5A5A_0000);
    endfunction

    // responder: ack lands ack_lat cycles after the first memReq cycle
    int ack_lat = 2;
    bit rnd_lat = 0;
    bit spur    = 0;
    initial begin
        int cnt;
        int cur_lat;
        cnt = 0;
        cur_lat = 1;
        bus.memAck = 1'b0;
        bus.memReadData = '0;
        forever begin
            @(posedge clk); #1;
            bus.memAck = 1'b0;
            bus.memReadData = $urandom;
            if (!resetN || !bus.memReq) cnt = 0;
            else begin
                if (cnt == 0) cur_lat = rnd_lat ? int'($urandom_range(1, 4)) : ack_lat;
                cnt++;
                if (cnt == cur_lat + 1) begin
                    bus.memAck = 1'b1;
                    if (bus.memWrite) mem[bus.memAddr] = bus.memWriteData;
                    else bus.memReadData = mem_rd(bus.memAddr);
                end
            end
            if (spur) begin
                bus.memAck = 1'b1;
                spur = 0;
            end
        end
    end

    // monitor: grant decisions and responses predicted from the arbitration rules
    logic [31:0] grant_log [$];
    initial begin
        bit prev_if, prev_dm, prev_mreq, outst, okind_dm, exp_dm, gw;
        int starve;
        logic [31:0] gaddr, gwd, last_dm;
        prev_if = 0; prev_dm = 0; prev_mreq = 0; outst = 0; okind_dm = 0; gw = 0;
        starve = 0; gaddr = 0; gwd = 0; last_dm = 0;
        forever begin
            @(negedge clk);
            if (!resetN) begin
                chk("reset_outs", {bus.memReq, bus.memWrite, bus.ifReady, bus.dmReady,
                                   |bus.memAddr, |bus.memWriteData, |bus.ifData, |bus.dmReadData}, 0);
                starve = 0; outst = 0; last_dm = 0;
            end else begin
                chk("if_stall", bus.ifStall, bus.ifReq & ~bus.ifReady);
                chk("dm_stall", bus.dmStall, bus.dmReq & ~bus.dmReady);
                if (bus.memReq && !prev_mreq) begin
                    chk("grant_while_busy", outst, 0);
                    chk("grant_has_req", prev_if | prev_dm, 1);
                    exp_dm = prev_dm && !(prev_if && starve == LIMIT);
                    if (exp_dm) begin
                        chk("grant_dm", {bus.memAddr, bus.memWriteData, bus.memWrite},
                                        {bus.dmAddr, bus.dmWriteData, bus.dmWrite});
                        starve = prev_if ? ((starve + 1 > LIMIT) ? LIMIT : starve + 1) : 0;
                    end else begin
                        chk("grant_if", {bus.memAddr, bus.memWriteData, bus.memWrite},
                                        {bus.ifAddr, 32'h0, 1'b0});
                        starve = 0;
                    end
                    outst = 1; okind_dm = exp_dm;
                    gaddr = bus.memAddr; gwd = bus.memWriteData; gw = bus.memWrite;
                    grant_log.push_back(bus.memAddr);
                end else if (bus.memReq) begin
                    chk("mem_hold", {bus.memAddr, bus.memWriteData, bus.memWrite}, {gaddr, gwd, gw});
                end
                if (bus.ifReady || bus.dmReady) begin
                    chk("ready_outstanding", outst, 1);
                    chk("ready_kind", {bus.ifReady, bus.dmReady}, okind_dm ? 2'b01 : 2'b10);
                    if (!okind_dm) chk("if_data", bus.ifData, ref_rd(gaddr));
                    else if (gw) begin
                        chk("store_keeps_rdata", bus.dmReadData, last_dm);
                        ref_mem[gaddr] = gwd;
                    end else begin
                        chk("dm_rdata", bus.dmReadData, ref_rd(gaddr));
                        last_dm = ref_rd(gaddr);
                    end
                    outst = 0;
                end
            end
            prev_if = bus.ifReq; prev_dm = bus.dmReq; prev_mreq = bus.memReq;
        end
    end

    typedef struct {
        bit          dm;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] exp_data;
    } vec_t;

    task automatic wait_ready(input bit dm, input string tag);
        int w;
        w = 0;
        do begin @(posedge clk); #1; w++; end
        while (!(dm ? bus.dmReady : bus.ifReady) && w < 200);
        chk(tag, w < 200, 1);
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        int w;
        @(posedge clk); #1;
        ack_lat = v.lat;
        if (v.dm) begin
            bus.dmWrite = v.wr; bus.dmAddr = v.addr; bus.dmWriteData = v.wdata; bus.dmReq = 1'b1;
        end else begin
            bus.ifAddr = v.addr; bus.ifReq = 1'b1;
        end
        w = 0;
        do begin @(posedge clk); #1; w++; end
        while (!(v.dm ? bus.dmReady : bus.ifReady) && w < 200);
        chk({tag, "_lat"}, w, v.lat + 2);
        chk({tag, "_data"}, v.dm ? bus.dmReadData : bus.ifData, v.exp_data);
        bus.dmReq = 1'b0; bus.ifReq = 1'b0;
    endtask

    task automatic wait_grants(input int n, input string tag);
        int w;
        w = 0;
        while (grant_log.size() < n && w < 400) begin @(posedge clk); #1; w++; end
        chk(tag, w < 400, 1);
    endtask

    task automatic if_driver(input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            bus.ifAddr = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
            bus.ifReq  = 1'b1;
            wait_ready(0, "rnd_if_timeout");
            bus.ifReq  = 1'b0;
        end
    endtask

    task automatic dm_driver(input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            bus.dmAddr      = 32'h1000 + {26'h0, 4'($urandom_range(0, 15)), 2'b00};
            bus.dmWrite     = 1'($urandom_range(0, 1));
            bus.dmWriteData = $urandom;
            bus.dmReq       = 1'b1;
            wait_ready(1, "rnd_dm_timeout");
            bus.dmReq       = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vec_t vecs [8];
        vecs[0] = '{0, 0, 32'h40,  32'h0,        2,  32'h0050_0093};
        vecs[1] = '{1, 1, 32'h100, 32'hDEADBEEF, 1,  32'h0};
        vecs[2] = '{1, 0, 32'h100, 32'h0,        2,  32'hDEADBEEF};
        vecs[3] = '{0, 0, 32'h44,  32'h0,        1,  32'h5A5A_0044};
        vecs[4] = '{1, 1, 32'h200, 32'h12345678, 3,  32'hDEADBEEF};
        vecs[5] = '{1, 0, 32'h200, 32'h0,        1,  32'h12345678};
        vecs[6] = '{0, 0, 32'h100, 32'h0,        2,  32'hDEADBEEF};
        vecs[7] = '{1, 0, 32'h300, 32'h0,        10, 32'h5A5A_0300};

        mem[32'h40] = 32'h0050_0093;
        ref_mem[32'h40] = 32'h0050_0093;
        resetN = 1'b0;
        bus.ifReq = 1'b1; bus.ifAddr = 32'h40;
        bus.dmReq = 1'b0; bus.dmWrite = 1'b0; bus.dmAddr = '0; bus.dmWriteData = '0;

        // reset with a pending fetch, then grant on the first edge
        repeat (3) @(negedge clk);
        chk("reset_memReq", bus.memReq, 0);
        #2 resetN = 1'b1;
        @(posedge clk); #1;
        chk("first_grant", {bus.memReq, bus.memAddr}, {1'b1, 32'h40});
        wait_ready(0, "first_ready_timeout");
        bus.ifReq = 1'b0;

        for (int i = 0; i < 8; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

        // spurious ack in IDLE
        @(posedge clk); #1;
        spur = 1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("spurious_no_ready", {bus.ifReady, bus.dmReady, bus.memReq}, 0);
        end

        // both ports held: DM x4, IF, DM x3 then reset in BUSY_DM
        ack_lat = 5;
        grant_log.delete();
        @(posedge clk); #1;
        bus.ifAddr = 32'h80; bus.ifReq = 1'b1;
        bus.dmAddr = 32'h1000; bus.dmWrite = 1'b0; bus.dmWriteData = '0; bus.dmReq = 1'b1;
        wait_grants(8, "starve_timeout");
        for (int i = 0; i < 8; i++)
            chk($sformatf("starve_order%0d", i), (i < grant_log.size()) ? grant_log[i] : 32'hX,
                (i == 4) ? 32'h80 : 32'h1000);
        #2 resetN = 1'b0;
        #1 chk("reset_abort_memReq", bus.memReq, 0);
        grant_log.delete();
        repeat (2) @(negedge clk);
        #2 resetN = 1'b1;
        wait_grants(5, "post_reset_timeout");
        for (int i = 0; i < 5; i++)
            chk($sformatf("post_reset_order%0d", i), (i < grant_log.size()) ? grant_log[i] : 32'hX,
                (i == 4) ? 32'h80 : 32'h1000);
        wait_ready(0, "post_reset_if_timeout");
        bus.ifReq = 1'b0;
        wait_ready(1, "post_reset_dm_timeout");
        bus.dmReq = 1'b0;

        // randomized contention
        rnd_lat = 1;
        fork
            if_driver(30);
            dm_driver(30);
        join
        rnd_lat = 0;
        repeat (4) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
